// File: rtl/configs_loader.sv
// ----------------------------------------------------------------------------
// configs_loader
//
// Upstream feeder for the configuration latch bank. Configuration words arrive
// on a valid/ready stream and are written to the latch bank strictly in order,
// one word per latch group. Each write runs set-up / strobe / hold so that a
// latch is only transparent while its data bus is stable.
//
// Handshake: a word is transferred on a rising edge where io_in_valid and
// io_in_ready are both high. io_in_ready is high only in WAIT and is forced
// low by io_abort in the same cycle, so an aborted cycle never consumes a word.
// The source may hold io_in_valid/io_in_bits for as long as ready stays low.
//
// Ports
//   clk            single clock, rising edge
//   reset          synchronous, active-high
//   io_start       pulse: begin loading at word 0 (honoured in IDLE or DONE)
//   io_abort       synchronous abort of the current load
//   io_in_valid    config word available
//   io_in_ready    loader can accept a word
//   io_in_bits     config word
//   io_d_out       registered data bus to the latch bank
//   io_configs_en  registered one-hot latch enables
//   io_word_idx    registered index of the word currently being written
//   io_busy        high in WAIT, SETUP, STROBE and HOLD
//   io_done        registered, high in DONE
//   dbg_state      current FSM state encoding
// ----------------------------------------------------------------------------
module configs_loader #(
    parameter int WORD_W    = 32,
    parameter int NUM_WORDS = 23,
    parameter int IDX_W     = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 io_start,
    input  logic                 io_abort,
    input  logic                 io_in_valid,
    output logic                 io_in_ready,
    input  logic [WORD_W-1:0]    io_in_bits,
    output logic [WORD_W-1:0]    io_d_out,
    output logic [NUM_WORDS-1:0] io_configs_en,
    output logic [IDX_W-1:0]     io_word_idx,
    output logic                 io_busy,
    output logic                 io_done,
    output logic [2:0]           dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WAIT   = 3'd1,
        S_SETUP  = 3'd2,
        S_STROBE = 3'd3,
        S_HOLD   = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);
    localparam logic [NUM_WORDS-1:0] EN_ONE = NUM_WORDS'(1);

    state_t state;
    state_t state_next;

    logic                 accept;
    logic                 start_ok;
    logic                 last_word;
    logic [NUM_WORDS-1:0] idx_onehot;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (io_start) state_next = S_WAIT;
            S_WAIT:   if (accept)   state_next = S_SETUP;
            S_SETUP:  state_next = S_STROBE;
            S_STROBE: state_next = S_HOLD;
            S_HOLD:   state_next = last_word ? S_DONE : S_WAIT;
            S_DONE:   if (io_start) state_next = S_WAIT;
            default:  state_next = S_IDLE;
        endcase
        // Abort overrides everything, including a simultaneous start.
        if (io_abort) begin
            state_next = S_IDLE;
        end
    end

    // ------------------------------------------------------------------
    // Decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        // Abort is the one input allowed to reach ready: it must stop a word
        // offered in the aborted cycle from being taken.
        io_in_ready = (state == S_WAIT) && !io_abort;
        io_busy     = (state == S_WAIT)  || (state == S_SETUP) ||
                      (state == S_STROBE) || (state == S_HOLD);
        dbg_state   = state;
    end

    assign accept     = io_in_valid && io_in_ready;
    assign start_ok   = io_start && !io_abort &&
                        ((state == S_IDLE) || (state == S_DONE));
    assign last_word  = (io_word_idx == LAST_IDX);
    assign idx_onehot = EN_ONE << io_word_idx;

    // ------------------------------------------------------------------
    // Registered datapath outputs
    // ------------------------------------------------------------------
    // The enable register is loaded while in SETUP, so the pulse appears for
    // exactly the STROBE cycle. Data is captured on accept, so it is already
    // on the bus for the whole of SETUP and is not touched again until the
    // next accept, which can only follow HOLD.
    always_ff @(posedge clk) begin
        if (reset) begin
            io_d_out      <= '0;
            io_configs_en <= '0;
            io_word_idx   <= '0;
            io_done       <= 1'b0;
        end else begin
            io_configs_en <= '0;
            if (io_abort) begin
                // Data bus deliberately left as is; latches keep their contents.
                io_word_idx <= '0;
                io_done     <= 1'b0;
            end else begin
                if (accept) begin
                    io_d_out <= io_in_bits;
                end
                if (state == S_SETUP) begin
                    io_configs_en <= idx_onehot;
                end
                if (start_ok) begin
                    io_word_idx <= '0;
                    io_done     <= 1'b0;
                end
                if (state == S_HOLD) begin
                    if (last_word) begin
                        // Index stays at the last word; no wrap-around.
                        io_done <= 1'b1;
                    end else begin
                        io_word_idx <= io_word_idx + IDX_W'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_configs_loader.sv
// ----------------------------------------------------------------------------
// tb_configs_loader
//
// Drives configs_loader with directed word sequences. Each accepted word
// pushes its expected enable pulse onto exp_q; a negedge monitor pops and
// compares whenever the DUT shows an enable pulse, and also checks one-hot
// enables and data-bus stability around every strobe.
// ----------------------------------------------------------------------------
module tb_configs_loader;

    localparam int WORD_W    = 32;
    localparam int NUM_WORDS = 23;
    localparam int IDX_W     = 5;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_WAIT   = 3'd1;
    localparam logic [2:0] ST_STROBE = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd5;

    localparam logic [WORD_W-1:0]    WORD_BASE = 32'hC0DE_0000;
    localparam logic [NUM_WORDS-1:0] EN_ONE    = 23'd1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic                 io_start = 1'b0;
    logic                 io_abort = 1'b0;
    logic                 io_in_valid = 1'b0;
    logic                 io_in_ready;
    logic [WORD_W-1:0]    io_in_bits = '0;
    logic [WORD_W-1:0]    io_d_out;
    logic [NUM_WORDS-1:0] io_configs_en;
    logic [IDX_W-1:0]     io_word_idx;
    logic                 io_busy;
    logic                 io_done;
    logic [2:0]           dbg_state;

    configs_loader #(
        .WORD_W    (WORD_W),
        .NUM_WORDS (NUM_WORDS),
        .IDX_W     (IDX_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .io_start      (io_start),
        .io_abort      (io_abort),
        .io_in_valid   (io_in_valid),
        .io_in_ready   (io_in_ready),
        .io_in_bits    (io_in_bits),
        .io_d_out      (io_d_out),
        .io_configs_en (io_configs_en),
        .io_word_idx   (io_word_idx),
        .io_busy       (io_busy),
        .io_done       (io_done),
        .dbg_state     (dbg_state)
    );

    // ---------------- scoreboard ----------------
    logic [NUM_WORDS+WORD_W-1:0] exp_q[$];
    int errors = 0;
    int checks = 0;
    int exp_idx = 0;

    int   ncyc = 0;
    int   first_acc = -1;
    int   done_cyc = -1;
    logic arm_first = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor ----------------
    logic [WORD_W-1:0]    prev_d = '0;
    logic [NUM_WORDS-1:0] prev_en = '0;
    logic                 prev_done = 1'b0;

    always @(negedge clk) begin
        logic [NUM_WORDS+WORD_W-1:0] item;
        ncyc++;
        if (!reset) begin
            check("en_onehot0", 64'($onehot0(io_configs_en)), 64'd1);
            if (io_configs_en != '0) begin
                check("en_only_in_strobe", 64'(dbg_state), 64'(ST_STROBE));
                check("d_stable_before_strobe", 64'(io_d_out), 64'(prev_d));
                check("en_single_cycle", 64'(prev_en), 64'd0);
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", 64'(io_configs_en), 64'd0);
                end else begin
                    item = exp_q.pop_front();
                    check("pulse_en", 64'(io_configs_en), 64'(item[WORD_W +: NUM_WORDS]));
                    check("pulse_data", 64'(io_d_out), 64'(item[WORD_W-1:0]));
                end
            end
            if (prev_en != '0) begin
                check("d_stable_after_strobe", 64'(io_d_out), 64'(prev_d));
            end
            if (io_in_valid && io_in_ready && arm_first) begin
                first_acc = ncyc;
                arm_first = 1'b0;
            end
            if (io_done && !prev_done) begin
                done_cyc = ncyc;
            end
        end
        prev_d    = io_d_out;
        prev_en   = io_configs_en;
        prev_done = io_done;
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        io_start = 1'b1;
        tick();
        io_start  = 1'b0;
        exp_idx   = 0;
        arm_first = 1'b1;
    endtask

    // Offers one word, optionally after `stall` idle cycles; returns one
    // cycle after the accepting edge (SETUP of that word).
    task automatic send_word(input logic [WORD_W-1:0] w, input int stall);
        int n;
        for (int i = 0; i < stall; i++) begin
            io_in_valid = 1'b0;
            tick();
        end
        if (stall > 0) begin
            check("stall_ready", 64'(io_in_ready), 64'd1);
            check("stall_en_zero", 64'(io_configs_en), 64'd0);
            check("stall_state", 64'(dbg_state), 64'(ST_WAIT));
        end
        io_in_valid = 1'b1;
        io_in_bits  = w;
        n = 0;
        while (!io_in_ready && n < 50) begin
            tick();
            n++;
        end
        if (!io_in_ready) begin
            check("accept_timeout", 64'd0, 64'd1);
        end else begin
            tick();
            exp_q.push_back({EN_ONE << exp_idx, w});
            exp_idx++;
        end
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!io_done && n < 20) begin
            tick();
            n++;
        end
        check("done_reached", 64'(io_done), 64'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [WORD_W-1:0] w7;
        logic [WORD_W-1:0] junk;

        // Reset, then idle for 5 cycles.
        repeat (3) tick();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("rst_en", 64'(io_configs_en), 64'd0);
            check("rst_ready", 64'(io_in_ready), 64'd0);
            check("rst_busy", 64'(io_busy), 64'd0);
            check("rst_done", 64'(io_done), 64'd0);
            check("rst_d_out", 64'(io_d_out), 64'd0);
        end

        // Load A: full load, valid held high.
        do_start();
        check("start_state", 64'(dbg_state), 64'(ST_WAIT));
        check("start_idx", 64'(io_word_idx), 64'd0);
        check("start_busy", 64'(io_busy), 64'd1);
        for (int k = 0; k < NUM_WORDS; k++) begin
            send_word(WORD_BASE + WORD_W'(k), 0);
        end
        wait_done();
        @(negedge clk);
        #1;
        check("done_latency", 64'(done_cyc - first_acc), 64'd92);
        check("done_idx_last", 64'(io_word_idx), 64'd22);
        check("done_busy", 64'(io_busy), 64'd0);
        check("done_ready", 64'(io_in_ready), 64'd0);
        check("done_d_out", 64'(io_d_out), 64'hC0DE_0016);
        io_in_valid = 1'b0;
        repeat (3) tick();
        check("done_held", 64'(io_done), 64'd1);
        check("done_state", 64'(dbg_state), 64'(ST_DONE));

        // Load B: start from DONE, start pulsed during word 3, stall before word 5.
        do_start();
        check("restart_done_low", 64'(io_done), 64'd0);
        check("restart_busy", 64'(io_busy), 64'd1);
        check("restart_idx", 64'(io_word_idx), 64'd0);
        for (int k = 0; k < NUM_WORDS; k++) begin
            if (k == 3) io_start = 1'b1;
            send_word(WORD_BASE + WORD_W'(k), (k == 5) ? 10 : 0);
            io_start = 1'b0;
            if (k == 3) begin
                check("start_ignored_idx", 64'(io_word_idx), 64'd3);
                check("start_ignored_busy", 64'(io_busy), 64'd1);
            end
            if (k == 5) begin
                check("w5_setup_en", 64'(io_configs_en), 64'd0);
                tick();
                check("w5_strobe_en", 64'(io_configs_en), 64'(EN_ONE << 5));
            end
        end
        wait_done();
        io_in_valid = 1'b0;

        // Load C: abort during STROBE of word 7.
        do_start();
        for (int k = 0; k < 8; k++) begin
            send_word(WORD_BASE + WORD_W'(k), 0);
        end
        w7 = WORD_BASE + WORD_W'(7);
        io_in_valid = 1'b0;
        tick();
        check("w7_strobe", 64'(io_configs_en), 64'(EN_ONE << 7));
        io_abort = 1'b1;
        tick();
        io_abort = 1'b0;
        check("abort_en", 64'(io_configs_en), 64'd0);
        check("abort_state", 64'(dbg_state), 64'(ST_IDLE));
        check("abort_busy", 64'(io_busy), 64'd0);
        check("abort_idx", 64'(io_word_idx), 64'd0);
        check("abort_d_kept", 64'(io_d_out), 64'(w7));

        // Abort in WAIT with a word on offer: not consumed.
        do_start();
        junk = WORD_W'($urandom_range(1, 32'h7FFF_FFFF));
        io_in_valid = 1'b1;
        io_in_bits  = junk;
        io_abort    = 1'b1;
        #1;
        check("abort_ready_low", 64'(io_in_ready), 64'd0);
        tick();
        io_abort    = 1'b0;
        io_in_valid = 1'b0;
        check("abort_wait_state", 64'(dbg_state), 64'(ST_IDLE));
        check("abort_wait_d_kept", 64'(io_d_out), 64'(w7));

        // Restart, then reset during HOLD of word 1.
        do_start();
        check("restart2_idx", 64'(io_word_idx), 64'd0);
        send_word(32'h1234_5678, 0);
        send_word(32'h9ABC_DEF0, 0);
        io_in_valid = 1'b0;
        tick();
        check("w1_strobe", 64'(io_configs_en), 64'(EN_ONE << 1));
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_d_out", 64'(io_d_out), 64'd0);
        check("midrst_state", 64'(dbg_state), 64'(ST_IDLE));
        check("midrst_idx", 64'(io_word_idx), 64'd0);
        check("midrst_en", 64'(io_configs_en), 64'd0);
        repeat (3) tick();

        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
